// File: rtl/uop_rename_stage.sv
// uop_rename_stage: 2-wide register rename with speculative/commit RAT and circular free list.
// Optional RENAME_STALL_CNT_EN adds o_stall_cnt, a saturating count of free-list starvation cycles.
module uop_rename_stage #(
    parameter  int NUM_PREG = 64,
    localparam int PW       = $clog2(NUM_PREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          i_in_valid,
    input  logic [1:0][4:0]     i_in_rs1,
    input  logic [1:0][4:0]     i_in_rs2,
    input  logic [1:0][4:0]     i_in_rd,
    input  logic [1:0]          i_in_rd_wen,
    output logic [1:0]          o_in_take,
    output logic [1:0]          o_out_valid,
    output logic [1:0][PW-1:0]  o_out_prs1,
    output logic [1:0][PW-1:0]  o_out_prs2,
    output logic [1:0][PW-1:0]  o_out_prd,
    output logic [1:0][PW-1:0]  o_out_old_prd,
    output logic [1:0]          o_out_rd_wen,
    input  logic                i_out_ready,
    input  logic                i_flush,
    input  logic [1:0]          i_cmt_valid,
    input  logic [1:0][4:0]     i_cmt_rd,
    input  logic [1:0][PW-1:0]  i_cmt_prd,
    input  logic [1:0][PW-1:0]  i_cmt_old_prd,
    output logic [PW:0]         o_fl_count
`ifdef RENAME_STALL_CNT_EN
    ,
    output logic [31:0]         o_stall_cnt
`endif
);
    localparam int FL = NUM_PREG - 32;
    localparam int FW = $clog2(FL);
    localparam logic [PW:0] FL_P  = (PW+1)'(FL);
    localparam logic [PW:0] FL2_P = (PW+1)'(2 * FL);

    // Pointers run modulo 2*FL so a full list and an empty list never share a pointer pair.
    function automatic logic [PW:0] pinc(input logic [PW:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = p + (PW+1)'(n);
        return (s >= FL2_P) ? s - FL2_P : s;
    endfunction

    function automatic logic [FW-1:0] pidx(input logic [PW:0] p);
        return FW'((p >= FL_P) ? p - FL_P : p);
    endfunction

    logic [PW-1:0]       r_spec_rat [32];
    logic [PW-1:0]       r_cmt_rat  [32];
    logic [PW-1:0]       r_fl       [FL];
    logic [PW:0]         r_head, r_cmt_head, r_tail, r_fl_count;
    logic [1:0]          r_out_valid, r_out_rd_wen;
    logic [1:0][PW-1:0]  r_out_prs1, r_out_prs2, r_out_prd, r_out_old_prd;

    logic                w_sfree;
    logic [1:0]          w_wen, w_take, w_alloc;
    logic [1:0]          w_nalloc, w_nfree;
    logic [1:0][PW-1:0]  w_prs1, w_prs2, w_prd, w_old;
    logic [PW:0]         w_head_n, w_cmt_head_n, w_tail_n, w_fl_count_n;
    logic [FW-1:0]       w_tidx0, w_tidx1;
    logic [PW-1:0]       w_cmt_rat_n [32];

    assign w_sfree  = !r_out_valid[0] || i_out_ready;
    assign w_wen[0] = i_in_rd_wen[0] && (i_in_rd[0] != '0);
    assign w_wen[1] = i_in_rd_wen[1] && (i_in_rd[1] != '0);

    always_comb begin
        w_take[0] = i_in_valid[0] && w_sfree && !i_flush
                    && (r_fl_count >= (PW+1)'(w_wen[0]));
        w_take[1] = w_take[0] && i_in_valid[1]
                    && (r_fl_count >= (PW+1)'({1'b0, w_wen[0]} + {1'b0, w_wen[1]}));
        w_alloc   = w_take & w_wen;
        w_nalloc  = {1'b0, w_alloc[0]} + {1'b0, w_alloc[1]};
        w_nfree   = {1'b0, i_cmt_valid[0]} + {1'b0, i_cmt_valid[1]};
        w_prd[0]  = w_wen[0] ? r_fl[pidx(r_head)] : '0;
        w_prd[1]  = w_wen[1] ? r_fl[pidx(pinc(r_head, {1'b0, w_wen[0]}))] : '0;
        // Slot1 sees slot0's fresh mapping for any register slot0 writes.
        w_prs1[0] = r_spec_rat[i_in_rs1[0]];
        w_prs2[0] = r_spec_rat[i_in_rs2[0]];
        w_prs1[1] = (w_wen[0] && i_in_rs1[1] == i_in_rd[0]) ? w_prd[0] : r_spec_rat[i_in_rs1[1]];
        w_prs2[1] = (w_wen[0] && i_in_rs2[1] == i_in_rd[0]) ? w_prd[0] : r_spec_rat[i_in_rs2[1]];
        w_old[0]  = w_wen[0] ? r_spec_rat[i_in_rd[0]] : '0;
        w_old[1]  = !w_wen[1] ? '0
                  : (w_wen[0] && i_in_rd[1] == i_in_rd[0]) ? w_prd[0] : r_spec_rat[i_in_rd[1]];
        w_tail_n     = pinc(r_tail, w_nfree);
        w_cmt_head_n = pinc(r_cmt_head, w_nfree);
        w_head_n     = i_flush ? w_cmt_head_n : pinc(r_head, w_nalloc);
        w_fl_count_n = !i_flush ? r_fl_count - (PW+1)'(w_nalloc) + (PW+1)'(w_nfree)
                     : (w_tail_n >= w_head_n) ? w_tail_n - w_head_n
                     : w_tail_n + FL2_P - w_head_n;
        w_tidx0 = pidx(r_tail);
        w_tidx1 = pidx(pinc(r_tail, {1'b0, i_cmt_valid[0]}));
        w_cmt_rat_n = r_cmt_rat;
        for (int k = 0; k < 2; k++)
            if (i_cmt_valid[k] && i_cmt_rd[k] != '0) w_cmt_rat_n[i_cmt_rd[k]] = i_cmt_prd[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_spec_rat[i] <= PW'(i);
                r_cmt_rat[i]  <= PW'(i);
            end
            for (int i = 0; i < FL; i++) r_fl[i] <= PW'(32 + i);
            r_head        <= '0;
            r_cmt_head    <= '0;
            r_tail        <= FL_P;
            r_fl_count    <= FL_P;
            r_out_valid   <= '0;
            r_out_rd_wen  <= '0;
            r_out_prs1    <= '0;
            r_out_prs2    <= '0;
            r_out_prd     <= '0;
            r_out_old_prd <= '0;
        end else begin
            r_head     <= w_head_n;
            r_cmt_head <= w_cmt_head_n;
            r_tail     <= w_tail_n;
            r_fl_count <= w_fl_count_n;
            if (i_cmt_valid[0]) r_fl[w_tidx0] <= i_cmt_old_prd[0];
            if (i_cmt_valid[1]) r_fl[w_tidx1] <= i_cmt_old_prd[1];
            r_cmt_rat <= w_cmt_rat_n;
            if (i_flush) r_spec_rat <= w_cmt_rat_n;
            else begin
                if (w_alloc[0]) r_spec_rat[i_in_rd[0]] <= w_prd[0];
                if (w_alloc[1]) r_spec_rat[i_in_rd[1]] <= w_prd[1];
            end
            r_out_valid <= i_flush ? '0 : (w_sfree ? w_take : r_out_valid);
            if (w_sfree) begin
                r_out_rd_wen  <= w_alloc;
                r_out_prs1    <= w_prs1;
                r_out_prs2    <= w_prs2;
                r_out_prd     <= w_prd;
                r_out_old_prd <= w_old;
            end
        end
    end

`ifdef RENAME_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stall_cnt <= '0;
        else if (i_in_valid[0] && w_sfree && !i_flush && !w_take[0] && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_in_take     = w_take;
    assign o_out_valid   = r_out_valid;
    assign o_out_rd_wen  = r_out_rd_wen;
    assign o_out_prs1    = r_out_prs1;
    assign o_out_prs2    = r_out_prs2;
    assign o_out_prd     = r_out_prd;
    assign o_out_old_prd = r_out_old_prd;
    assign o_fl_count    = r_fl_count;
endmodule

// File: tb/tb_uop_rename_stage.sv
// tb_uop_rename_stage: random + directed stimulus checked against a queue-based rename model.
module tb_uop_rename_stage;
    localparam int PW = 6;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic [1:0]          in_valid, in_rd_wen, in_take, out_valid, out_rd_wen, cmt_valid;
    logic [1:0][4:0]     in_rs1, in_rs2, in_rd, cmt_rd;
    logic [1:0][PW-1:0]  out_prs1, out_prs2, out_prd, out_old_prd, cmt_prd, cmt_old_prd;
    logic                out_ready, flush;
    logic [PW:0]         fl_count;
`ifdef RENAME_STALL_CNT_EN
    logic [31:0]         stall_cnt;
`endif

    uop_rename_stage #(.NUM_PREG(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_rd(in_rd),
        .i_in_rd_wen(in_rd_wen), .o_in_take(in_take), .o_out_valid(out_valid),
        .o_out_prs1(out_prs1), .o_out_prs2(out_prs2), .o_out_prd(out_prd),
        .o_out_old_prd(out_old_prd), .o_out_rd_wen(out_rd_wen), .i_out_ready(out_ready),
        .i_flush(flush), .i_cmt_valid(cmt_valid), .i_cmt_rd(cmt_rd), .i_cmt_prd(cmt_prd),
        .i_cmt_old_prd(cmt_old_prd), .o_fl_count(fl_count)
`ifdef RENAME_STALL_CNT_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    typedef struct {int rd; int prd; int old;} rec_t;
    int   spec_rat[32], cmt_rat[32];
    int   fl_q[$];
    rec_t infl[$];
    bit   m_ov[2], m_wen[2], m_take[2];
    int   m_prs1[2], m_prs2[2], m_prd[2], m_old[2];
    longint m_stall;
    int   n_cmp, n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin spec_rat[i] = i; cmt_rat[i] = i; end
        fl_q.delete();
        for (int i = 32; i < 64; i++) fl_q.push_back(i);
        infl.delete();
        m_ov = '{0, 0};
        m_stall = 0;
    endfunction

    function automatic bit wen_of(input int k);
        return in_rd_wen[k] && in_rd[k] != 0;
    endfunction

    task automatic compare();
        bit sfree;
        int w0, w1;
        sfree = !m_ov[0] || out_ready;
        w0 = int'(wen_of(0));
        w1 = int'(wen_of(1));
        m_take[0] = in_valid[0] && sfree && !flush && fl_q.size() >= w0;
        m_take[1] = m_take[0] && in_valid[1] && fl_q.size() >= w0 + w1;
        chk("in_take", 32'(in_take), 32'({m_take[1], m_take[0]}));
        chk("out_valid", 32'(out_valid), 32'({m_ov[1], m_ov[0]}));
        chk("fl_count", 32'(fl_count), 32'(fl_q.size()));
        for (int k = 0; k < 2; k++)
            if (m_ov[k])
                chk($sformatf("slot%0d_prs1_prs2_prd_old_wen", k),
                    32'({out_prs1[k], out_prs2[k], out_prd[k], out_old_prd[k], out_rd_wen[k]}),
                    32'({PW'(m_prs1[k]), PW'(m_prs2[k]), PW'(m_prd[k]), PW'(m_old[k]), m_wen[k]}));
`ifdef RENAME_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
    endtask

    task automatic update();
        bit sfree;
        sfree = !m_ov[0] || out_ready;
        for (int k = 0; k < 2; k++)
            if (cmt_valid[k]) begin
                fl_q.push_back(int'(cmt_old_prd[k]));
                cmt_rat[cmt_rd[k]] = int'(cmt_prd[k]);
                void'(infl.pop_front());
            end
        for (int k = 0; k < 2; k++)
            if (m_take[k]) begin
                m_prs1[k] = spec_rat[in_rs1[k]];
                m_prs2[k] = spec_rat[in_rs2[k]];
                m_wen[k]  = wen_of(k);
                m_prd[k]  = 0;
                m_old[k]  = 0;
                if (m_wen[k]) begin
                    m_old[k] = spec_rat[in_rd[k]];
                    m_prd[k] = fl_q.pop_front();
                    spec_rat[in_rd[k]] = m_prd[k];
                    infl.push_back('{int'(in_rd[k]), m_prd[k], m_old[k]});
                end
            end
        if (sfree) m_ov = m_take;
        if (in_valid[0] && sfree && !flush && !m_take[0] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (flush) begin
            for (int i = infl.size() - 1; i >= 0; i--) fl_q.push_front(infl[i].prd);
            infl.delete();
            spec_rat = cmt_rat;
            m_ov = '{0, 0};
        end
    endtask

    task automatic step();
        #1;
        compare();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_rd_wen = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        out_ready = 1; flush = 0;
        cmt_valid = 0; cmt_rd = 0; cmt_prd = 0; cmt_old_prd = 0;
    endtask

    task automatic set_uop(input int k, input bit v, input int rs1, input int rs2, input int rd,
                           input bit wen);
        in_valid[k] = v; in_rs1[k] = 5'(rs1); in_rs2[k] = 5'(rs2);
        in_rd[k] = 5'(rd); in_rd_wen[k] = wen;
    endtask

    task automatic set_cmt(input int n);
        cmt_valid = 0;
        for (int k = 0; k < n; k++) begin
            cmt_valid[k] = 1;
            cmt_rd[k] = 5'(infl[k].rd);
            cmt_prd[k] = PW'(infl[k].prd);
            cmt_old_prd[k] = PW'(infl[k].old);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_fl_count", 32'(fl_count), 32);
        idle();
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic int rreg();
        return ($urandom % 4 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        n_cmp = 0; n_err = 0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        // pair x1=x2+x3, x4=x1+x5
        set_uop(0, 1, 2, 3, 1, 1); set_uop(1, 1, 1, 5, 4, 1);
        step(); idle();
        chk("t1_prd0", 32'(out_prd[0]), 32);
        chk("t1_prd1", 32'(out_prd[1]), 33);
        chk("t1_prs1_1", 32'(out_prs1[1]), 32);
        chk("t1_old0", 32'(out_old_prd[0]), 1);
        chk("t1_old1", 32'(out_old_prd[1]), 4);
        chk("t1_fl_count", 32'(fl_count), 30);
        // both slots write x7
        do_reset();
        set_uop(0, 1, 1, 2, 7, 1); set_uop(1, 1, 3, 4, 7, 1);
        step(); idle();
        chk("t2_prd0", 32'(out_prd[0]), 32);
        chk("t2_prd1", 32'(out_prd[1]), 33);
        chk("t2_old1", 32'(out_old_prd[1]), 32);
        set_uop(0, 1, 7, 0, 0, 0);
        step(); idle();
        chk("t2_next_prs1", 32'(out_prs1[0]), 33);
        // slot1 writes x0 and reads x0
        do_reset();
        set_uop(0, 1, 1, 2, 3, 1); set_uop(1, 1, 0, 0, 0, 1);
        step(); idle();
        chk("t6_prd1", 32'(out_prd[1]), 0);
        chk("t6_prs1_1", 32'(out_prs1[1]), 0);
        chk("t6_prs2_1", 32'(out_prs2[1]), 0);
        chk("t6_fl_count", 32'(fl_count), 31);
        // exhaust the free list, then one commit restarts renaming
        do_reset();
        for (int c = 0; c < 16; c++) begin
            set_uop(0, 1, 0, 0, (2 * c) % 31 + 1, 1); set_uop(1, 1, 0, 0, (2 * c + 1) % 31 + 1, 1);
            step();
        end
        idle();
        chk("t3_fl_empty", 32'(fl_count), 0);
        set_uop(0, 1, 0, 0, 5, 1);
        #1 chk("t3_starved_take", 32'(in_take), 0);
        set_cmt(1);
        step();
        cmt_valid = 0;
        step();
        chk("t3_reuse_prd", 32'(out_prd[0]), 1);
        // commit the oldest of three writers together with a flush
        do_reset();
        for (int c = 1; c <= 3; c++) begin set_uop(0, 1, 0, 0, c, 1); step(); end
        idle();
        set_cmt(1); flush = 1;
        step(); idle();
        chk("t4_fl_count", 32'(fl_count), 32);
        set_uop(0, 1, 1, 2, 4, 1);
        step(); idle();
        chk("t4_prd", 32'(out_prd[0]), 33);
        chk("t4_prs1", 32'(out_prs1[0]), 32);
        chk("t4_prs2", 32'(out_prs2[0]), 2);
        // downstream backpressure
        do_reset();
        set_uop(0, 1, 0, 0, 1, 1); set_uop(1, 1, 0, 0, 2, 1);
        step();
        set_uop(0, 1, 0, 0, 3, 1); set_uop(1, 1, 0, 0, 4, 1); out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t5_hold_take", 32'(in_take), 0);
            chk("t5_hold_prd1", 32'(out_prd[1]), 33);
            step();
        end
        out_ready = 1;
        step(); idle();
        chk("t5_flow_prd0", 32'(out_prd[0]), 34);
        // randomized traffic, alternating starvation-prone and commit-heavy phases
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int rate, n;
            rate = ((c / 500) % 2 == 1) ? 15 : 70;
            for (int k = 0; k < 2; k++)
                set_uop(k, ($urandom % 5) != 0, rreg(), rreg(), rreg(), ($urandom % 4) != 0);
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 50) == 0;
            n = (($urandom % 100) < rate) ? int'($urandom_range(1, 2)) : 0;
            if (n > infl.size()) n = infl.size();
            set_cmt(n);
            step();
            if (c == 1500) do_reset();
        end
        idle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
